// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV64 execute stage.
package riscv_pkg;
  localparam int XLEN      = 64;
  localparam int MUL_ITERS = 64;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU,
    ALU_MUL, ALU_MULHU
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_op(alu_op_t op);
    return op inside {ALU_MUL, ALU_MULHU};
  endfunction
endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: radix-2 shift-add multiplier, one operand bit per cycle.
// Present only when RV64_MUL_EN is defined.
`ifdef RV64_MUL_EN
module ex_mul_iter
  import riscv_pkg::*;
#(
  parameter int ITERS = MUL_ITERS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            hi_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);
  localparam int CW = $clog2(ITERS);

  mul_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              hi_q, hi_d;

  // Next-state: latch operands on start, accumulate one partial product per BUSY cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    case (state_q)
      MUL_IDLE: if (start_i) begin
        state_d = MUL_BUSY;
        a_d     = a_i;
        b_d     = b_i;
        hi_d    = hi_i;
        acc_d   = '0;
        cnt_d   = '0;
      end
      MUL_BUSY: begin
        acc_d = acc_q + (b_q[cnt_q] ? ({{XLEN{1'b0}}, a_q} << cnt_q) : '0);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITERS - 1)) state_d = MUL_DONE;
      end
      default: state_d = MUL_IDLE;
    endcase
    if (flush_i && state_q != MUL_IDLE) state_d = MUL_IDLE;
  end

  // Multiplier state registers; reset discards any partial product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
    end
  end

  assign busy_o    = state_q == MUL_BUSY;
  assign done_o    = state_q == MUL_DONE;
  assign product_o = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: RV64 execute stage with MEM/WB forwarding, single-cycle ALU and EX/MEM register.
// Define RV64_MUL_EN to include the iterative MUL/MULHU unit; otherwise MUL ops retire as
// non-writing instructions with result 0 and stall_o is tied low.
module ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  alu_op_t         alu_op_i,
  input  logic            reg_write_i,
  input  logic            alu_src_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_reg_write_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_reg_write_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_addr_o,
  output logic            reg_write_o,
  output logic            valid_o
);
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, mul_product;
  logic            mem_hit_a, wb_hit_a, mem_hit_b, wb_hit_b, is_mul, bubble;
  logic [XLEN-1:0] result_q, result_d, store_q, store_d;
  logic [4:0]      rd_q, rd_d;
  logic            rw_q, rw_d, valid_q, valid_d;

  assign mem_hit_a = mem_reg_write_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == rs1_addr_i;
  assign wb_hit_a  = wb_reg_write_i  && wb_rd_addr_i  != 5'd0 && wb_rd_addr_i  == rs1_addr_i;
  assign mem_hit_b = mem_reg_write_i && mem_rd_addr_i != 5'd0 && mem_rd_addr_i == rs2_addr_i;
  assign wb_hit_b  = wb_reg_write_i  && wb_rd_addr_i  != 5'd0 && wb_rd_addr_i  == rs2_addr_i;
  assign fwd_a     = mem_hit_a ? mem_result_i : wb_hit_a ? wb_result_i : rs1_data_i;
  assign fwd_b     = mem_hit_b ? mem_result_i : wb_hit_b ? wb_result_i : rs2_data_i;
  assign op_b      = alu_src_i ? imm_i : fwd_b;
  assign is_mul    = is_mul_op(alu_op_i);
  assign bubble    = !valid_i || flush_i || stall_o;

`ifdef RV64_MUL_EN
  localparam bit MUL_HW = 1'b1;
  logic mul_busy, mul_done, mul_start;

  // A new multiply may only start from IDLE; a flush drops the stall in the same cycle.
  assign mul_start = valid_i && is_mul && !flush_i && !mul_busy && !mul_done;
  assign stall_o   = mul_start || (mul_busy && !flush_i);

  ex_mul_iter #(.ITERS(MUL_ITERS)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mul_start),
    .flush_i  (flush_i),
    .a_i      (fwd_a),
    .b_i      (fwd_b),
    .hi_i     (alu_op_i == ALU_MULHU),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  localparam bit MUL_HW = 1'b0;
  assign stall_o     = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle ALU on the forwarded operands.
  always_comb begin
    case (alu_op_i)
      ALU_ADD:  alu_res = fwd_a + op_b;
      ALU_SUB:  alu_res = fwd_a - op_b;
      ALU_AND:  alu_res = fwd_a & op_b;
      ALU_OR:   alu_res = fwd_a | op_b;
      ALU_XOR:  alu_res = fwd_a ^ op_b;
      ALU_SLL:  alu_res = fwd_a << op_b[5:0];
      ALU_SRL:  alu_res = fwd_a >> op_b[5:0];
      ALU_SRA:  alu_res = $signed(fwd_a) >>> op_b[5:0];
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, fwd_a < op_b};
      default:  alu_res = '0;
    endcase
  end

  // EX/MEM next value: a bubble loads all zeros; a multiply only gets here in its DONE cycle.
  always_comb begin
    result_d = '0;
    store_d  = '0;
    rd_d     = '0;
    rw_d     = 1'b0;
    valid_d  = 1'b0;
    if (!bubble) begin
      result_d = is_mul ? mul_product : alu_res;
      store_d  = fwd_b;
      rd_d     = rd_addr_i;
      rw_d     = reg_write_i && (MUL_HW || !is_mul);
      valid_d  = 1'b1;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      rw_q     <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o     = result_q;
  assign store_data_o = store_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = rw_q;
  assign valid_o      = valid_q;
endmodule
